// File: rtl/jtpopeye_pkg.sv
// Shared geometry for the jtpopeye video timing generator.
// Holds the Popeye board defaults plus the set/clear window helper that the
// timer and its window sub-blocks both use.
package jtpopeye_pkg;

  localparam int POP_HW        = 9;
  localparam int POP_VW        = 9;
  localparam int POP_H_TOTAL   = 384;
  localparam int POP_HB_START  = 256;
  localparam int POP_HB_END    = 0;
  localparam int POP_HS_START  = 296;
  localparam int POP_HS_END    = 328;
  localparam int POP_V_TOTAL   = 264;
  localparam int POP_VB_START  = 240;
  localparam int POP_VB_END    = 16;
  localparam int POP_VS_START  = 248;
  localparam int POP_VS_END    = 252;
  localparam int POP_FLIP_LSB  = 3;
  localparam int POP_DMA_ALIGN = 3;

  // Set wins over clear; START==END is never configured so they cannot collide.
  function automatic logic win_next(input logic cur, input logic hit_set,
                                    input logic hit_clr);
    if (hit_set) return 1'b1;
    if (hit_clr) return 1'b0;
    return cur;
  endfunction

endpackage

// File: rtl/jtpopeye_vtimer_win.sv
// Set/clear compare window: flag rises when the next count equals START and
// falls when it equals END, so windows may straddle the counter wrap.
// Ports: clk, rst_n, en (update strobe), cnt_d (next count), flag (registered).
module jtpopeye_vtimer_win
  import jtpopeye_pkg::*;
#(
  parameter int W     = 9,
  parameter int START = 0,
  parameter int END   = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] cnt_d,
  output logic         flag
);

  localparam logic [W-1:0] START_C = W'(START);
  localparam logic [W-1:0] END_C   = W'(END);

  logic flag_d, flag_q;

  always_comb begin
    flag_d = flag_q;
    if (en) flag_d = win_next(flag_q, cnt_d == START_C, cnt_d == END_C);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flag_q <= 1'b0;
    else        flag_q <= flag_d;
  end

  assign flag = flag_q;

endmodule

// File: rtl/jtpopeye_vtimer.sv
// Parametrised video timing: H/V counters, blank/sync windows, DMA-safe blank,
// screen flip and frame-event pulses. All state advances only on cen.
// Ports: clk, rst_n, cen, flip in; H/V (flipped), Hraw/Vraw, HB/VB/HS/VS,
// HBD_n, vb_start, line_start, frame out.
module jtpopeye_vtimer
  import jtpopeye_pkg::*;
#(
  parameter int HW        = POP_HW,
  parameter int VW        = POP_VW,
  parameter int H_TOTAL   = POP_H_TOTAL,
  parameter int HB_START  = POP_HB_START,
  parameter int HB_END    = POP_HB_END,
  parameter int HS_START  = POP_HS_START,
  parameter int HS_END    = POP_HS_END,
  parameter int V_TOTAL   = POP_V_TOTAL,
  parameter int VB_START  = POP_VB_START,
  parameter int VB_END    = POP_VB_END,
  parameter int VS_START  = POP_VS_START,
  parameter int VS_END    = POP_VS_END,
  parameter int FLIP_LSB  = POP_FLIP_LSB,
  parameter int DMA_ALIGN = POP_DMA_ALIGN
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          flip,
  output logic [HW-1:0] H,
  output logic [VW-1:0] V,
  output logic [HW-1:0] Hraw,
  output logic [VW-1:0] Vraw,
  output logic          HB,
  output logic          VB,
  output logic          HS,
  output logic          VS,
  output logic          HBD_n,
  output logic          vb_start,
  output logic          line_start,
  output logic          frame
);

  if (H_TOTAL > 2**HW || V_TOTAL > 2**VW ||
      HB_START >= H_TOTAL || HB_END >= H_TOTAL ||
      HS_START >= H_TOTAL || HS_END >= H_TOTAL ||
      VB_START >= V_TOTAL || VB_END >= V_TOTAL ||
      VS_START >= V_TOTAL || VS_END >= V_TOTAL ||
      DMA_ALIGN < 1 || DMA_ALIGN > HW || FLIP_LSB >= HW) begin : g_bad_geometry
    $error("jtpopeye_vtimer: timing parameters out of range");
  end

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VB_SET   = VW'(VB_START);
  localparam logic [HW-1:0] DMA_MASK = (HW'(1) << DMA_ALIGN) - HW'(1);
  // Bits at and above FLIP_LSB invert under flip; the low pixel bits do not.
  localparam logic [HW-1:0] H_FLIP   = ~((HW'(1) << FLIP_LSB) - HW'(1));

  logic [HW-1:0] hraw_d, hraw_q;
  logic [VW-1:0] vraw_d, vraw_q;
  logic          hb_l_d, hb_l_q;
  logic          vb_start_d, vb_start_q;
  logic          line_start_d, line_start_q;
  logic          frame_d, frame_q;
  logic          h_wrap, line_tick, vb_rise;

  assign h_wrap    = (hraw_q == H_LAST);
  assign line_tick = cen & h_wrap;
  // VB can only be low when the line count reaches START, so hitting START
  // on a line tick is exactly the 0->1 edge.
  assign vb_rise   = line_tick & (vraw_d == VB_SET);

  always_comb begin
    hraw_d       = hraw_q;
    vraw_d       = vraw_q;
    hb_l_d       = hb_l_q;
    vb_start_d   = vb_start_q;
    line_start_d = line_start_q;
    frame_d      = frame_q;
    if (cen) begin
      hraw_d       = h_wrap ? '0 : hraw_q + HW'(1);
      line_start_d = h_wrap;
      vb_start_d   = vb_rise;
      frame_d      = frame_q ^ vb_rise;
      if (h_wrap) vraw_d = (vraw_q == V_LAST) ? '0 : vraw_q + VW'(1);
      // DMA may start only on a group boundary once blanking is under way.
      if ((hraw_q & DMA_MASK) == DMA_MASK) hb_l_d = HB;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hraw_q       <= '0;
      vraw_q       <= '0;
      hb_l_q       <= 1'b0;
      vb_start_q   <= 1'b0;
      line_start_q <= 1'b0;
      frame_q      <= 1'b0;
    end else begin
      hraw_q       <= hraw_d;
      vraw_q       <= vraw_d;
      hb_l_q       <= hb_l_d;
      vb_start_q   <= vb_start_d;
      line_start_q <= line_start_d;
      frame_q      <= frame_d;
    end
  end

  jtpopeye_vtimer_win #(.W(HW), .START(HB_START), .END(HB_END)) u_hb (
    .clk(clk), .rst_n(rst_n), .en(cen), .cnt_d(hraw_d), .flag(HB));
  jtpopeye_vtimer_win #(.W(HW), .START(HS_START), .END(HS_END)) u_hs (
    .clk(clk), .rst_n(rst_n), .en(cen), .cnt_d(hraw_d), .flag(HS));
  jtpopeye_vtimer_win #(.W(VW), .START(VB_START), .END(VB_END)) u_vb (
    .clk(clk), .rst_n(rst_n), .en(line_tick), .cnt_d(vraw_d), .flag(VB));
  jtpopeye_vtimer_win #(.W(VW), .START(VS_START), .END(VS_END)) u_vs (
    .clk(clk), .rst_n(rst_n), .en(line_tick), .cnt_d(vraw_d), .flag(VS));

  assign Hraw       = hraw_q;
  assign Vraw       = vraw_q;
  assign H          = hraw_q ^ (flip ? H_FLIP : '0);
  assign V          = vraw_q ^ {VW{flip}};
  assign HBD_n      = ~(hb_l_q & HB);
  assign vb_start   = vb_start_q;
  assign line_start = line_start_q;
  assign frame      = frame_q;

endmodule

// File: tb/tb_jtpopeye_vtimer.sv
module tb_jtpopeye_vtimer;

  logic clk = 1'b0;
  logic rst_n, cen_d, cen_s, flip;
  always #5 clk = ~clk;

  // Default Popeye geometry
  logic [8:0] H_d, V_d, Hraw_d, Vraw_d;
  logic HB_d, VB_d, HS_d, VS_d, HBD_n_d, vbs_d, ls_d, fr_d;

  jtpopeye_vtimer u_def (
    .clk(clk), .rst_n(rst_n), .cen(cen_d), .flip(flip),
    .H(H_d), .V(V_d), .Hraw(Hraw_d), .Vraw(Vraw_d),
    .HB(HB_d), .VB(VB_d), .HS(HS_d), .VS(VS_d), .HBD_n(HBD_n_d),
    .vb_start(vbs_d), .line_start(ls_d), .frame(fr_d));

  // Small geometry: 16 pixels x 8 lines
  logic [3:0] H_s, V_s, Hraw_s, Vraw_s;
  logic HB_s, VB_s, HS_s, VS_s, HBD_n_s, vbs_s, ls_s, fr_s;

  jtpopeye_vtimer #(
    .HW(4), .VW(4), .H_TOTAL(16), .HB_START(12), .HB_END(2),
    .HS_START(13), .HS_END(14), .V_TOTAL(8), .VB_START(6), .VB_END(1),
    .VS_START(7), .VS_END(0), .FLIP_LSB(3), .DMA_ALIGN(2)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .cen(cen_s), .flip(flip),
    .H(H_s), .V(V_s), .Hraw(Hraw_s), .Vraw(Vraw_s),
    .HB(HB_s), .VB(VB_s), .HS(HS_s), .VS(VS_s), .HBD_n(HBD_n_s),
    .vb_start(vbs_s), .line_start(ls_s), .frame(fr_s));

  int n_tests = 0;
  int n_fail  = 0;
  int n_d     = 0;
  int n_s     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One cen on the default instance; sample 1 time unit after the edge.
  task automatic step_d_to(input int target);
    while (n_d < target) begin
      cen_d = 1'b1;
      @(posedge clk); #1;
      cen_d = 1'b0;
      n_d++;
    end
  endtask

  // Small instance: a cen clock followed by an idle clock, so pulses are
  // observed after a non-cen edge.
  task automatic step_s;
    cen_s = 1'b1;
    @(posedge clk); #1;
    cen_s = 1'b0;
    @(posedge clk); #1;
    n_s++;
  endtask

  typedef struct {
    int   step;
    int   hraw;
    int   vraw;
    logic hb, hs, vb, vs, hbd_n, ls, vbs, fr;
  } vec_t;

  vec_t tbl[16];

  int   exp_h, exp_v, cnt_vbs, cnt_ls, cnt_vb, cnt_fr, bad_cnt;
  logic prev_fr;

  initial begin
    // step  hraw vraw  hb hs vb vs hbd_n ls vbs fr
    tbl[0]  = '{0,   0,  0, 0, 0, 0, 0, 1, 0, 0, 0};
    tbl[1]  = '{1,   1,  0, 0, 0, 0, 0, 1, 0, 0, 0};
    tbl[2]  = '{12, 12,  0, 1, 0, 0, 0, 1, 0, 0, 0};
    tbl[3]  = '{13, 13,  0, 1, 1, 0, 0, 1, 0, 0, 0};
    tbl[4]  = '{14, 14,  0, 1, 0, 0, 0, 1, 0, 0, 0};
    tbl[5]  = '{15, 15,  0, 1, 0, 0, 0, 1, 0, 0, 0};
    tbl[6]  = '{16,  0,  1, 1, 0, 0, 0, 0, 1, 0, 0};
    tbl[7]  = '{17,  1,  1, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[8]  = '{18,  2,  1, 0, 0, 0, 0, 1, 0, 0, 0};
    tbl[9]  = '{96,  0,  6, 1, 0, 1, 0, 0, 1, 1, 1};
    tbl[10] = '{97,  1,  6, 1, 0, 1, 0, 0, 0, 0, 1};
    tbl[11] = '{112, 0,  7, 1, 0, 1, 1, 0, 1, 0, 1};
    tbl[12] = '{127, 15, 7, 1, 0, 1, 1, 1, 0, 0, 1};
    tbl[13] = '{128, 0,  0, 1, 0, 1, 0, 0, 1, 0, 1};
    tbl[14] = '{144, 0,  1, 1, 0, 0, 0, 0, 1, 0, 1};
    tbl[15] = '{224, 0,  6, 1, 0, 1, 0, 0, 1, 1, 0};

    rst_n = 1'b0; cen_d = 1'b0; cen_s = 1'b0; flip = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // Reset values of the default instance
    chk("rst_hraw", Hraw_d, 0);
    chk("rst_vraw", Vraw_d, 0);
    chk("rst_flags", {HB_d, VB_d, HS_d, VS_d, vbs_d, ls_d, fr_d}, 0);
    chk("rst_hbd_n", HBD_n_d, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Small geometry: table of hand-computed points along the first frames
    for (int i = 0; i < 16; i++) begin
      while (n_s < tbl[i].step) step_s();
      chk($sformatf("s%0d_hraw", tbl[i].step), Hraw_s, tbl[i].hraw);
      chk($sformatf("s%0d_vraw", tbl[i].step), Vraw_s, tbl[i].vraw);
      chk($sformatf("s%0d_hb", tbl[i].step), HB_s, tbl[i].hb);
      chk($sformatf("s%0d_hs", tbl[i].step), HS_s, tbl[i].hs);
      chk($sformatf("s%0d_vb", tbl[i].step), VB_s, tbl[i].vb);
      chk($sformatf("s%0d_vs", tbl[i].step), VS_s, tbl[i].vs);
      chk($sformatf("s%0d_hbd_n", tbl[i].step), HBD_n_s, tbl[i].hbd_n);
      chk($sformatf("s%0d_line_start", tbl[i].step), ls_s, tbl[i].ls);
      chk($sformatf("s%0d_vb_start", tbl[i].step), vbs_s, tbl[i].vbs);
      chk($sformatf("s%0d_frame", tbl[i].step), fr_s, tbl[i].fr);
    end

    // Two further frames on the small instance: periods and event counts
    cnt_vbs = 0; cnt_ls = 0; cnt_vb = 0; cnt_fr = 0; bad_cnt = 0;
    prev_fr = fr_s;
    for (int k = 0; k < 256; k++) begin
      step_s();
      exp_h = n_s % 16;
      exp_v = (n_s / 16) % 8;
      if (Hraw_s != 4'(exp_h) || Vraw_s != 4'(exp_v)) bad_cnt++;
      if (VB_s !== ((exp_v >= 6) || (exp_v < 1))) bad_cnt++;
      if (HBD_n_s !== !(exp_h < 2)) bad_cnt++;
      cnt_vbs += int'(vbs_s);
      cnt_ls  += int'(ls_s);
      cnt_vb  += int'(VB_s);
      if (fr_s !== prev_fr) cnt_fr++;
      prev_fr = fr_s;
    end
    chk("s_frames_count_errs", bad_cnt, 0);
    chk("s_frames_vb_start", cnt_vbs, 2);
    chk("s_frames_line_start", cnt_ls, 16);
    chk("s_frames_vb_cycles", cnt_vb, 96);
    chk("s_frames_frame_toggles", cnt_fr, 2);

    // Default geometry: horizontal windows along line 0
    step_d_to(1);   chk("d1_hraw", Hraw_d, 1);
    step_d_to(255); chk("d255_hb", HB_d, 0);
    step_d_to(256); chk("d256_hb", HB_d, 1);
    step_d_to(263); chk("d263_hbd_n", HBD_n_d, 1);
    step_d_to(264); chk("d264_hbd_n", HBD_n_d, 0);
    step_d_to(295); chk("d295_hs", HS_d, 0);
    step_d_to(296); chk("d296_hs", HS_d, 1);
    step_d_to(327); chk("d327_hs", HS_d, 1);
    step_d_to(328); chk("d328_hs", HS_d, 0);
    step_d_to(383); chk("d383_hraw", Hraw_d, 383);
    step_d_to(384);
    chk("d384_hraw", Hraw_d, 0);
    chk("d384_vraw", Vraw_d, 1);
    chk("d384_line_start", ls_d, 1);
    chk("d384_hb", HB_d, 0);
    chk("d384_hbd_n", HBD_n_d, 1);
    step_d_to(385); chk("d385_line_start", ls_d, 0);

    // Flip at Hraw=5, Vraw=16
    step_d_to(16 * 384 + 5);
    chk("noflip_h", H_d, 9'h005);
    chk("noflip_v", V_d, 9'h010);
    flip = 1'b1; #1;
    chk("flip_h", H_d, 9'h1FD);
    chk("flip_v", V_d, 9'h1EF);
    chk("flip_hraw", Hraw_d, 9'h005);
    chk("flip_vraw", Vraw_d, 9'h010);
    flip = 1'b0;

    // cen low for 100 clocks: nothing moves
    repeat (100) @(posedge clk);
    #1;
    chk("hold_hraw", Hraw_d, 5);
    chk("hold_vraw", Vraw_d, 16);
    chk("hold_h", H_d, 5);
    chk("hold_flags", {HB_d, VB_d, HS_d, VS_d, vbs_d, ls_d, fr_d}, 0);
    chk("hold_hbd_n", HBD_n_d, 1);

    // Asynchronous reset mid-frame at Hraw=200, Vraw=100
    step_d_to(100 * 384 + 200);
    chk("pre_rst_hraw", Hraw_d, 200);
    chk("pre_rst_vraw", Vraw_d, 100);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_hraw", Hraw_d, 0);
    chk("arst_vraw", Vraw_d, 0);
    chk("arst_flags", {HB_d, VB_d, HS_d, VS_d, vbs_d, ls_d, fr_d}, 0);
    chk("arst_hbd_n", HBD_n_d, 1);
    chk("arst_small_hraw", Hraw_s, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle_hraw", Hraw_d, 0);
    n_d = 0;
    step_d_to(1);
    chk("post_rst_hraw", Hraw_d, 1);
    chk("post_rst_vraw", Vraw_d, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
